shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Controller that sequences a serial shift chain.
- Accepts a parallel word over a valid/ready handshake and loads it into an internal WIDTH-bit shift register.
- Clocks the word out MSB-first on shift_out while capturing shift_in into the vacated LSB positions.
- Presents the captured word on a second valid/ready handshake. Sits between a parallel producer/consumer and a serial link or external flip-flop chain.

Parameters:
- WIDTH, 4, bits per transfer; legal values are 2 and above.
- DIV, 1, clock cycles per shift step; legal values are 1 and above. One shift occurs every DIV cycles.

Ports:
- clock  input  1  system clock; all state updates on the positive edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  sequencer accepts in_data this cycle.
- in_data  input  WIDTH  parallel word to serialize.
- shift_in  input  1  serial input, sampled on shift steps.
- shift_out  output  1  serial output; equals sreg[WIDTH-1] in SHIFT, otherwise 0.
- shift_en  output  1  one-cycle strobe marking the edge on which a shift step occurs.
- out_valid  output  1  captured word is available.
- out_ready  input  1  consumer takes out_data.
- out_data  output  WIDTH  captured serial word.
- busy  output  1  high in SHIFT or HOLD.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, sreg=0, bit_cnt=0, div_cnt=0.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_data=0, shift_out=0, shift_en=0, busy=0.
- Reset mid-transfer: the transfer is aborted. No out_valid is produced, and the partial word is discarded.
- States: IDLE, SHIFT, HOLD (registered).
- in_ready = (state==IDLE) or (state==HOLD and out_ready). This is combinational from out_ready, with no dependence on in_valid.
- Accept: an input handshake is in_valid and in_ready at a clock edge. On accept: sreg<=in_data, bit_cnt<=0, div_cnt<=0, state<=SHIFT.
- IDLE: all outputs at their reset values. in_valid low keeps the block in IDLE.
- SHIFT:
  - busy=1, in_ready=0. in_valid is ignored; in_data is not sampled.
  - div_cnt counts 0..DIV-1. The step cycle is the cycle where div_cnt==DIV-1; in that cycle shift_en=1.
  - Step edge: sreg<={sreg[WIDTH-2:0], shift_in}, bit_cnt++, div_cnt<=0.
  - Non-step edge: div_cnt++.
  - Step with bit_cnt==WIDTH-1: state<=HOLD.
  - With DIV=1, shift_en is high for every SHIFT cycle.
- Latency: the word is accepted at edge E. SHIFT occupies exactly WIDTH*DIV cycles. out_valid rises in the cycle after edge E+WIDTH*DIV.
- HOLD:
  - out_valid=1, out_data=sreg, held stable until handshake. shift_out=0, shift_en=0.
  - out_ready=1 with in_valid=0: state<=IDLE.
  - out_ready=1 with in_valid=1 (back-to-back): output handshake and new accept complete on the same edge, state<=SHIFT, with no IDLE bubble.
- out_data equals sreg whenever out_valid=1. When out_valid=0, out_data is 0.
- Counters: bit_cnt is $clog2(WIDTH) bits and never exceeds WIDTH-1. div_cnt is max(1,$clog2(DIV)) bits and wraps at DIV-1.

Test Plan:
- WIDTH=4, DIV=1, shift_in tied to shift_out (loopback), load 4'b1011 -> shift_out reads 1,0,1,1 on 4 consecutive cycles, shift_en is high for those 4 cycles, out_valid rises 4 cycles after accept, out_data=4'b1011.
- WIDTH=4, DIV=3, shift_in driven with 1,1,0,1 on the step cycles, load 4'b0000 -> shift_en pulses every 3rd cycle (4 pulses over 12 cycles), out_data=4'b1101, busy high for 12+ cycles.
- Backpressure: out_ready=0 for 10 cycles in HOLD, in_valid=1 throughout -> in_ready stays 0, out_data remains stable, no new load; then out_ready=1 -> output handshake and new accept occur on the same edge.
- Back-to-back: two words 4'hA and 4'h5 with out_ready=1 -> second SHIFT starts on the edge after first HOLD entry, and the 8 shift_en pulses have only a 1-cycle gap (the HOLD cycle).
- Reset asserted asynchronously mid-SHIFT, after 2 steps -> outputs immediately return to reset values, no out_valid; after release, a new load of 4'b0110 completes correctly.
- in_valid pulsed during SHIFT with in_data=4'hF -> ignored; the word in flight is unaffected.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Takes a parallel word over a valid/ready handshake and shifts it out
//   MSB-first on shift_out. In the same steps it captures shift_in into the
//   vacated LSBs. The captured word is then offered on a second valid/ready
//   handshake. One shift step happens every DIV clock cycles.
//
// Ports
//   clock, reset           system clock, async active-high reset
//   in_valid/in_ready      input handshake, in_data = word to serialize
//   shift_in/shift_out     serial link (shift_out is 0 outside SHIFT)
//   shift_en               strobe marking the edge of each shift step
//   out_valid/out_ready    output handshake, out_data = captured word
//   busy                   high while shifting or holding a result
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a word; all outputs at reset values
// S_SHIFT | serializing; one step when div_cnt reaches DIV-1
// S_HOLD  | captured word on out_data until the consumer takes it

module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             shift_in,
    output logic             shift_out,
    output logic             shift_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    logic             step;
    logic             last_step;
    logic             accept;

    always_comb begin
        step      = (state == S_SHIFT) && (div_cnt == DW'(DIV - 1));
        last_step = step && (bit_cnt == BW'(WIDTH - 1));
        // A result in HOLD can be handed off and replaced on the same edge.
        in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
        accept    = in_valid && in_ready;
        shift_out = (state == S_SHIFT) ? sreg[WIDTH-1] : 1'b0;
        shift_en  = step;
        out_valid = (state == S_HOLD);
        out_data  = (state == S_HOLD) ? sreg : '0;
        busy      = (state == S_SHIFT) || (state == S_HOLD);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_SHIFT;
            S_SHIFT: if (last_step) state_nxt = S_HOLD;
            S_HOLD: begin
                if (accept)
                    state_nxt = S_SHIFT;
                else if (out_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sreg    <= in_data;
                bit_cnt <= '0;
                div_cnt <= '0;
            end else if (step) begin
                sreg    <= {sreg[WIDTH-2:0], shift_in};
                div_cnt <= '0;
                // Saturate on the final step so bit_cnt stays within 0..WIDTH-1.
                if (!last_step)
                    bit_cnt <= bit_cnt + 1'b1;
            end else if (state == S_SHIFT) begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule
